argon_regfile_mp: RTL

Parametrised next-generation Argon register file: NUM_REGS registers of DATA_W bits with a hardwired zero register r0, driven over the single shared CPU bus. Like the current register file, it latches A/B/C index fields from the bus and serves output-A, output-B and latch-C commands. It adds three things: registered bus output with a one-cycle valid strobe, post-increment of the C index for block transfers, and a sticky error flag for illegal command combinations. It sits between the control sequencer and the shared data bus.

---
 rtl/argon_regfile_mp.sv | 107 ++++++++++
 1 files changed

// File: rtl/argon_regfile_mp.sv
// Argon register file with hardwired r0, registered bus reads with a one-cycle valid
// strobe, post-incrementing C index for block transfers and a sticky command-conflict flag.
module argon_regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_bus,
  output logic              o_bus_valid,
  input  logic              i_selectLatch,
  input  logic              i_outputA,
  input  logic              i_outputB,
  input  logic              i_latchC,
  input  logic              i_incC,
  input  logic              i_errClear,
  output logic              o_err,
  output logic [IDX_W-1:0]  o_indexC
);

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_SEL,
    CMD_RDA,
    CMD_RDB,
    CMD_WRC
  } cmd_e;

  cmd_e              cmd;
  logic [2:0]        cmd_count;
  logic              conflict;
  logic [IDX_W-1:0]  index_a;
  logic [IDX_W-1:0]  index_b;
  logic [IDX_W-1:0]  index_c;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  c_plus;
  logic [IDX_W-1:0]  c_next;
  logic [DATA_W-1:0] rd_data;

  // r0 has no storage; the array starts at r1.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  // Fixed-priority decode: selectLatch > outputA > outputB > latchC.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cmd = CMD_NONE;
    if (i_selectLatch)  cmd = CMD_SEL;
    else if (i_outputA) cmd = CMD_RDA;
    else if (i_outputB) cmd = CMD_RDB;
    else if (i_latchC)  cmd = CMD_WRC;
  end

  assign cmd_count = 3'(i_selectLatch) + 3'(i_outputA) + 3'(i_outputB) + 3'(i_latchC);
  assign conflict  = (cmd_count > 3'd1);

  assign rd_idx  = (cmd == CMD_RDA) ? index_a : index_b;
  assign rd_data = (rd_idx == '0) ? '0 : regs[rd_idx];

  // NUM_REGS is a power of two, so top index + 1 rolls to 0; both that and 0 map to 1.
  assign c_plus = index_c + IDX_W'(1);
  assign c_next = (c_plus == '0) ? IDX_W'(1) : c_plus;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      index_a     <= '0;
      index_b     <= '0;
      index_c     <= '0;
      o_bus       <= '0;
      o_bus_valid <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      o_bus_valid <= 1'b0;
      case (cmd)
        CMD_SEL: begin
          index_a <= i_bus[IDX_W-1:0];
          index_b <= i_bus[2*IDX_W-1:IDX_W];
          index_c <= i_bus[3*IDX_W-1:2*IDX_W];
        end
        CMD_RDA, CMD_RDB: begin
          o_bus       <= rd_data;
          o_bus_valid <= 1'b1;
        end
        CMD_WRC: begin
          if (i_incC) index_c <= c_next;
        end
        default: ;
      endcase
      if (conflict)        o_err <= 1'b1;
      else if (i_errClear) o_err <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      // NOTE: the storage must clear on reset, so it is built from resettable flops rather than a RAM macro.
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (cmd == CMD_WRC && index_c != '0) begin
      regs[index_c] <= i_bus;
    end
  end

  assign o_indexC = index_c;

endmodule
